// File: rtl/data_mem_responder.sv
// Word-organised scratch data memory answering the CPU data port.
// BUSYWAIT stalls the core for LATENCY cycles, then one DONE cycle presents the load result.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  DATA_MEM_READ,
  input  logic [2:0]  DATA_MEM_WRITE,
  input  logic [31:0] DATA_MEM_ADDR,
  input  logic [31:0] DATA_MEM_WRITE_DATA,
  output logic [31:0] DATA_MEM_READ_DATA,
  output logic        DATA_MEM_BUSYWAIT
);

  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  rd_q;
  logic [2:0]  wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          req;
  logic          finish;
  logic [3:0]    cur_rd;
  logic [2:0]    cur_wr;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [IW-1:0] idx;
  logic [31:0]   word_rd;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ld_val;
  logic [31:0]   rdata_d;
  logic [3:0]    be;
  logic [31:0]   st_data;
  logic          do_store;
  logic          unused_addr_bits;

  assign req = DATA_MEM_READ[3] | DATA_MEM_WRITE[2];

  // With LATENCY=1 the commit edge leaves IDLE directly, so the live request is used there.
  assign cur_rd    = (state_q == IDLE) ? DATA_MEM_READ       : rd_q;
  assign cur_wr    = (state_q == IDLE) ? DATA_MEM_WRITE      : wr_q;
  assign cur_addr  = (state_q == IDLE) ? DATA_MEM_ADDR       : addr_q;
  assign cur_wdata = (state_q == IDLE) ? DATA_MEM_WRITE_DATA : wdata_q;

  assign finish = !RESET &&
                  (((state_q == IDLE) && req && (LATENCY == 1)) ||
                   ((state_q == BUSY) && (cnt_q == 4'd1)));

  assign idx              = cur_addr[IW+1:2];
  assign word_rd          = mem_q[idx];
  assign unused_addr_bits = ^cur_addr[31:IW+2];

  always_comb begin
    byte_v = word_rd[7:0];
    case (cur_addr[1:0])
      2'd0: byte_v = word_rd[7:0];
      2'd1: byte_v = word_rd[15:8];
      2'd2: byte_v = word_rd[23:16];
      2'd3: byte_v = word_rd[31:24];
      default: byte_v = word_rd[7:0];
    endcase
    half_v = cur_addr[1] ? word_rd[31:16] : word_rd[15:0];
    ld_val = 32'd0;
    case (cur_rd[2:0])
      3'b000: ld_val = {{24{byte_v[7]}}, byte_v};
      3'b001: ld_val = {{16{half_v[15]}}, half_v};
      3'b010: ld_val = word_rd;
      3'b100: ld_val = {24'd0, byte_v};
      3'b101: ld_val = {16'd0, half_v};
      default: ld_val = 32'd0;
    endcase
  end

  // A combined read+write is treated as a store, so the load result is forced to zero.
  assign rdata_d = cur_wr[2] ? 32'd0 : ld_val;

  always_comb begin
    be      = 4'b0000;
    st_data = 32'd0;
    case (cur_wr[1:0])
      2'b00: begin
        be      = 4'b0001 << cur_addr[1:0];
        st_data = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be      = cur_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{cur_wdata[15:0]}};
      end
      2'b10: begin
        be      = 4'b1111;
        st_data = cur_wdata;
      end
      default: begin
        be      = 4'b0000;
        st_data = 32'd0;
      end
    endcase
  end

  assign do_store = finish && cur_wr[2];

  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (do_store && be[b]) mem_q[idx][8*b +: 8] <= st_data[8*b +: 8];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 4'd0;
      wr_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            rd_q    <= DATA_MEM_READ;
            wr_q    <= DATA_MEM_WRITE;
            addr_q  <= DATA_MEM_ADDR;
            wdata_q <= DATA_MEM_WRITE_DATA;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= (LATENCY > 1) ? BUSY : DONE;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (finish && cur_rd[3]) rdata_q <= rdata_d;
    end
  end

  assign DATA_MEM_READ_DATA = rdata_q;
  assign DATA_MEM_BUSYWAIT  = !RESET && (((state_q == IDLE) && req) || (state_q == BUSY));

endmodule
